// File: rtl/intc_vec.sv
// Vectored interrupt controller: NUM_IRQ edge-triggered channels, fixed priority, jump vectors.
// Optional nesting (lower-index channels preempt running handlers) is enabled with INTC_NEST_EN.
module intc_vec #(
  parameter int                  NUM_IRQ    = 2,
  parameter int                  ID_W       = 1,
  parameter int                  PC_WIDTH   = 10,
  parameter logic [PC_WIDTH-1:0] VEC_BASE   = 10'h3E0,
  parameter int                  VEC_STRIDE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_in,
  input  logic                boundary,
  input  logic                reti,
  output logic                int_req,
  output logic [PC_WIDTH-1:0] int_vec,
  output logic [ID_W-1:0]     int_id,
  output logic [NUM_IRQ-1:0]  pending,
  output logic [NUM_IRQ-1:0]  in_service,
  output logic [NUM_IRQ-1:0]  mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Lowest set index wins; an all-zero vector yields index 0, callers gate on |bits.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] bits);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] idx);
    return NUM_IRQ'(1'b1) << idx;
  endfunction

  function automatic logic [PC_WIDTH-1:0] vec_addr(input logic [ID_W-1:0] idx);
    return VEC_BASE + PC_WIDTH'(int'(idx) * VEC_STRIDE);
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [NUM_IRQ-1:0]  irq_q_r;
  logic [NUM_IRQ-1:0]  rise_s;
  logic [NUM_IRQ-1:0]  eligible_s;
  logic [ID_W-1:0]     best_s;
  logic [NUM_IRQ-1:0]  pending_clr_s;
  logic [NUM_IRQ-1:0]  pending_nxt_s;
  logic [NUM_IRQ-1:0]  in_service_nxt_s;
  logic [ID_W-1:0]     id_nxt_s;
  logic [PC_WIDTH-1:0] vec_nxt_s;
  logic                int_req_nxt_s;

  assign rise_s     = irq & ~irq_q_r;
  assign eligible_s = pending & mask;
  assign best_s     = lowest_idx(eligible_s);

`ifdef INTC_NEST_EN
  logic [ID_W-1:0]    active_s;
  logic [NUM_IRQ-1:0] retired_s;

  assign active_s  = lowest_idx(in_service);
  assign retired_s = in_service & ~onehot(active_s);
`endif

  // Next-state, grant latch and pending/in-service bookkeeping.
  always_comb begin
    state_nxt_s      = state_r;
    pending_clr_s    = {NUM_IRQ{1'b0}};
    in_service_nxt_s = in_service;
    id_nxt_s         = int_id;
    vec_nxt_s        = int_vec;
    case (state_r)
      IDLE: begin
        if (|eligible_s) begin
          id_nxt_s    = best_s;
          vec_nxt_s   = vec_addr(best_s);
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        // Grant is frozen until the control unit reaches a boundary.
        if (boundary) begin
          pending_clr_s    = onehot(int_id);
          in_service_nxt_s = in_service | onehot(int_id);
          state_nxt_s      = SERVICE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      SERVICE: begin
`ifdef INTC_NEST_EN
        if (reti) begin
          in_service_nxt_s = retired_s;
          if (|retired_s) begin
            id_nxt_s    = lowest_idx(retired_s);
            vec_nxt_s   = vec_addr(lowest_idx(retired_s));
            state_nxt_s = SERVICE;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if ((|eligible_s) && (best_s < active_s)) begin
          id_nxt_s    = best_s;
          vec_nxt_s   = vec_addr(best_s);
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = SERVICE;
        end
`else
        if (reti) begin
          in_service_nxt_s = in_service & ~onehot(int_id);
          state_nxt_s      = IDLE;
        end else begin
          state_nxt_s = SERVICE;
        end
`endif
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // A fresh edge on the channel being taken keeps it pending.
    pending_nxt_s = (pending & ~pending_clr_s) | rise_s;
    int_req_nxt_s = (state_nxt_s == REQ);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      irq_q_r    <= {NUM_IRQ{1'b0}};
      pending    <= {NUM_IRQ{1'b0}};
      in_service <= {NUM_IRQ{1'b0}};
      mask       <= {NUM_IRQ{1'b0}};
      int_id     <= {ID_W{1'b0}};
      int_vec    <= {PC_WIDTH{1'b0}};
      int_req    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      irq_q_r    <= irq;
      pending    <= pending_nxt_s;
      in_service <= in_service_nxt_s;
      int_id     <= id_nxt_s;
      int_vec    <= vec_nxt_s;
      int_req    <= int_req_nxt_s;
      if (mask_we) begin
        mask <= mask_in;
      end else begin
        mask <= mask;
      end
    end
  end

endmodule

// File: tb/tb_intc_vec.sv
// Scoreboard bench for intc_vec: a behavioural model predicts grants and register state,
// a monitor compares them with the DUT every cycle.
module tb_intc_vec;
  localparam int              NUM_IRQ    = 2;
  localparam int              ID_W       = 1;
  localparam int              PC_WIDTH   = 10;
  localparam logic [9:0]      VEC_BASE   = 10'h3E0;
  localparam int              VEC_STRIDE = 4;

  logic clk = 1'b0;
  logic reset, mask_we, boundary, reti, int_req;
  logic [NUM_IRQ-1:0]  irq, mask_in, pending, in_service, mask;
  logic [PC_WIDTH-1:0] int_vec;
  logic [ID_W-1:0]     int_id;

  always #5 clk = ~clk;

  intc_vec #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W), .PC_WIDTH(PC_WIDTH),
             .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE)) dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .boundary(boundary), .reti(reti), .int_req(int_req), .int_vec(int_vec),
    .int_id(int_id), .pending(pending), .in_service(in_service), .mask(mask));

  typedef struct { int cyc; int id; int vec; } grant_t;
  typedef struct { int cyc; int pend; int insvc; int msk; } snap_t;
  grant_t gq[$];
  snap_t  sq[$];
  int cyc = 0;
  int vectors = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: pending flags, stack of active handlers, one outstanding grant.
  bit m_pend[NUM_IRQ];
  bit m_mask[NUM_IRQ];
  bit m_prev[NUM_IRQ];
  int m_active[$];
  bit m_req;
  int m_gid;

  function automatic int pack(input bit a[NUM_IRQ]);
    int v = 0;
    for (int k = 0; k < NUM_IRQ; k++) if (a[k]) v = v | (1 << k);
    return v;
  endfunction

  task automatic model_step();
    int best;
    int insvc;
    best = -1;
    if (reset) begin
      for (int k = 0; k < NUM_IRQ; k++) begin
        m_pend[k] = 1'b0; m_mask[k] = 1'b0; m_prev[k] = 1'b0;
      end
      m_active.delete();
      m_req = 1'b0;
      m_gid = 0;
    end else begin
      for (int k = NUM_IRQ - 1; k >= 0; k--) if (m_pend[k] && m_mask[k]) best = k;
      if (m_req) begin
        if (boundary) begin
          m_pend[m_gid] = 1'b0;
          m_active.push_back(m_gid);
          m_active.sort();
          m_req = 1'b0;
        end
      end else if (m_active.size() == 0) begin
        if (best >= 0) begin
          m_req = 1'b1;
          m_gid = best;
        end
      end else begin
        if (reti) void'(m_active.pop_front());
`ifdef INTC_NEST_EN
        else if (best >= 0 && best < m_active[0]) begin
          m_req = 1'b1;
          m_gid = best;
        end
`endif
      end
      for (int k = 0; k < NUM_IRQ; k++) begin
        if (irq[k] && !m_prev[k]) m_pend[k] = 1'b1;
        m_prev[k] = irq[k];
        if (mask_we) m_mask[k] = mask_in[k];
      end
    end
    if (m_req) gq.push_back('{cyc + 1, m_gid, (int'(VEC_BASE) + m_gid * VEC_STRIDE) & 32'h3FF});
    insvc = 0;
    foreach (m_active[i]) insvc = insvc | (1 << m_active[i]);
    sq.push_back('{cyc + 1, pack(m_pend), insvc, pack(m_mask)});
  endtask

  // Monitor: pops expectations and compares against what the DUT presents.
  always @(posedge clk) begin
    grant_t g;
    snap_t  s;
    #1;
    if (int_req) begin
      vectors++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant: int_req=1 at cycle %0d, required no request", cyc);
      end else begin
        g = gq.pop_front();
        if (g.cyc != cyc || g.id != int'(int_id) || g.vec != int'(int_vec)) begin
          errors++;
          $display("FAIL grant: cycle %0d id %0d vec %h, required cycle %0d id %0d vec %h",
                   cyc, int_id, int_vec, g.cyc, g.id, g.vec[9:0]);
        end
      end
    end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
      vectors++;
      errors++;
      g = gq.pop_front();
      $display("FAIL grant: int_req=0 at cycle %0d, required id %0d", cyc, g.id);
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      vectors++;
      if (s.cyc != cyc || s.pend != int'(pending) || s.insvc != int'(in_service) || s.msk != int'(mask)) begin
        errors++;
        $display("FAIL state: cycle %0d pend %b insvc %b mask %b, required cycle %0d pend %0h insvc %0h mask %0h",
                 cyc, pending, in_service, mask, s.cyc, s.pend, s.insvc, s.msk);
      end
    end
  end

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic expect_now(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq = 2'b00; mask_we = 1'b0; mask_in = 2'b00; boundary = 1'b0; reti = 1'b0;
    @(negedge clk);

    // Held requests through reset become edges once reset drops; nothing fires while masked.
    irq = 2'b11; do_reset();
    tick();
    expect_now("reset_mask", int'(mask), 0);
    expect_now("reset_req", int'(int_req), 0);
    expect_now("reset_pend", int'(pending), 3);
    mask_we = 1'b1; mask_in = 2'b11; tick(); mask_we = 1'b0;
    tick();
    expect_now("first_req", int'(int_req), 1);
    expect_now("first_id", int'(int_id), 0);
    expect_now("first_vec", int'(int_vec), 32'h3E0);
    boundary = 1'b1; tick(); boundary = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
    irq = 2'b00; tick();
    expect_now("second_id", int'(int_id), 1);

    // Single pulse on channel 1, latency and take.
    do_reset();
    mask_we = 1'b1; mask_in = 2'b10; tick(); mask_we = 1'b0;
    irq = 2'b10; tick();
    irq = 2'b00;
    expect_now("lat_pend", int'(pending), 2);
    expect_now("lat_req_early", int'(int_req), 0);
    tick();
    expect_now("lat_req", int'(int_req), 1);
    expect_now("lat_vec", int'(int_vec), 32'h3E4);
    for (int i = 0; i < 5; i++) tick();
    expect_now("hold_req", int'(int_req), 1);
    expect_now("hold_id", int'(int_id), 1);
    boundary = 1'b1; tick(); boundary = 1'b0;
    expect_now("take_pend", int'(pending), 0);
    expect_now("take_insvc", int'(in_service), 2);
    expect_now("take_req", int'(int_req), 0);

    // Channel 0 arrives while channel 1 is in service.
    irq = 2'b01; mask_we = 1'b1; mask_in = 2'b11; tick(); mask_we = 1'b0; irq = 2'b00;
    tick();
`ifdef INTC_NEST_EN
    expect_now("nest_req", int'(int_req), 1);
    expect_now("nest_id", int'(int_id), 0);
    boundary = 1'b1; tick(); boundary = 1'b0;
    expect_now("nest_insvc", int'(in_service), 3);
    reti = 1'b1; tick();
    expect_now("nest_reti1", int'(in_service), 2);
    tick(); reti = 1'b0;
    expect_now("nest_reti2", int'(in_service), 0);
`else
    expect_now("flat_wait", int'(int_req), 0);
    reti = 1'b1; tick(); reti = 1'b0;
    expect_now("flat_reti", int'(in_service), 0);
    tick();
    expect_now("flat_next", int'(int_req), 1);
    expect_now("flat_next_vec", int'(int_vec), 32'h3E0);
    boundary = 1'b1; tick(); boundary = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
`endif

    // Masked pending bit is retained and fires once unmasked.
    do_reset();
    irq = 2'b10; tick(); irq = 2'b00; tick(); tick();
    expect_now("masked_pend", int'(pending), 2);
    expect_now("masked_req", int'(int_req), 0);
    mask_we = 1'b1; mask_in = 2'b10; tick(); mask_we = 1'b0;
    tick();
    expect_now("unmask_req", int'(int_req), 1);

    // Randomised traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NUM_IRQ; k++) if ($urandom_range(0, 5) == 0) irq[k] = ~irq[k];
      boundary = ($urandom_range(0, 2) != 0);
      reti     = ($urandom_range(0, 4) == 0);
      mask_we  = ($urandom_range(0, 15) == 0);
      mask_in  = NUM_IRQ'($urandom_range(0, 3));
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; irq = 2'b00; boundary = 1'b0; reti = 1'b0; mask_we = 1'b0;
    tick(); tick();
    @(posedge clk); #2;
    expect_now("grant_queue_drained", gq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intc_vec.md
Name: intc_vec

Overview:
- Parametrised vectored interrupt controller for the single-cycle CPU.
- Generalises the fixed two-line interrupt inputs of the control unit to NUM_IRQ edge-triggered channels.
- Adds per-channel masking, fixed priority, pending and in-service tracking, and vector generation.
- Sits beside the control unit. It requests a jump to the vector and a push of the return PC onto the subroutine stack. The control unit reports instruction boundaries and return-from-interrupt.

Parameters:
- NUM_IRQ, 2: number of interrupt channels (1..16).
- ID_W, 1: width of the channel index; must equal max(1, ceil(log2(NUM_IRQ))).
- PC_WIDTH, 10: program-counter width.
- VEC_BASE, 10'h3E0: address of the channel 0 vector.
- VEC_STRIDE, 4: address distance between consecutive vectors.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  NUM_IRQ  raw requests, synchronous to clk, rising-edge sensitive.
- mask_we  in  1  write strobe for the mask register.
- mask_in  in  NUM_IRQ  new mask value; 1 = channel enabled.
- boundary  in  1  high when the control unit can replace the next PC in this cycle.
- reti  in  1  decoded return-from-interrupt instruction.
- int_req  out  1  take interrupt: control unit selects int_vec as next PC and pushes the return PC.
- int_vec  out  PC_WIDTH  vector address of the granted channel.
- int_id  out  ID_W  index of the granted channel.
- pending  out  NUM_IRQ  latched, not-yet-taken requests.
- in_service  out  NUM_IRQ  channels whose handler is active.
- mask  out  NUM_IRQ  current mask register.

Behaviour:
- Reset (synchronous, active-high): clears irq_q, pending, in_service, mask, int_id and int_vec to 0. State goes to IDLE; int_req is 0 from the next cycle. Reset mid-operation discards any request or service in progress.
- Edge detect: irq_q <= irq every cycle; rise = irq & ~irq_q. An irq held high through reset is seen as an edge on the first cycle after reset.
- Pending: a bit is set on rise and cleared when that channel is taken. If rise and take hit the same bit in the same cycle, set wins and the bit stays pending.
- Mask: mask <= mask_in when mask_we is high. Masking does not clear pending bits. Masked pending bits are retained and become eligible when unmasked.
- Eligible set: eligible = pending & mask. Priority is fixed; the lowest index wins.
- States: IDLE, REQ, SERVICE.
- IDLE: if eligible != 0, latch int_id = highest-priority eligible index and int_vec = VEC_BASE + int_id*VEC_STRIDE (truncated to PC_WIDTH), then go to REQ.
- REQ: int_req = 1 (registered output, high only in REQ).
  - int_id and int_vec stay frozen; a later higher-priority edge or a mask change does not alter or cancel the grant.
  - On a cycle with boundary = 1: clear pending[int_id], set in_service[int_id], go to SERVICE. int_req drops on the next cycle, so int_req overlaps boundary for exactly one cycle.
- SERVICE: no new requests. On reti, clear in_service[int_id] and go to IDLE. A new eligible request can enter REQ one cycle after that.
- reti in IDLE or REQ is ignored.
- Latency: rise sampled in cycle n; pending visible in n+1; int_req high in n+2 (IDLE, eligible, unmasked).
- Simultaneous events:
  - reti and a new rise in the same cycle: both take effect.
  - mask_we and rise in the same cycle: the pending bit is set regardless of the new mask.

Optional Feature:
- Macro INTC_NEST_EN.
- When defined, SERVICE also evaluates eligible:
  - If the best eligible index is lower than the lowest set in_service index, latch it and go to REQ (preemption). in_service may then hold several bits.
  - reti clears the lowest-index set in_service bit. The block returns to IDLE only when in_service becomes 0; otherwise it stays in SERVICE.
  - int_id restores to the lowest remaining in_service index for the next reti.
- When not defined, at most one in_service bit is ever set and SERVICE ignores all requests until reti.

Test Plan:
- Reset with irq=2'b11 -> mask=0, int_req=0; after mask_we with mask_in=2'b11, int_req asserts with int_id=0 and int_vec=10'h3E0.
- mask=2'b10, pulse irq[1] at cycle n, boundary=1 -> int_req high at n+2, int_vec=10'h3E4, pending[1] clears and in_service=2'b10 at n+3.
- Both channels enabled; irq[1] edge one cycle before irq[0] -> channel 1 is granted (frozen) and served; after reti, channel 0 is granted next with int_vec=10'h3E0.
- Hold boundary=0 for 5 cycles during REQ -> int_req stays high, int_id is unchanged, no pending or in_service change; boundary=1 completes the take.
- irq[1] pulses while its mask bit is 0 -> pending[1]=1 with no request; setting the mask bit -> int_req follows.
- INTC_NEST_EN: while servicing channel 1, raise irq[0] -> int_req with int_id=0 and in_service=2'b11; the first reti leaves 2'b10; the second reti returns to IDLE with in_service=0. Without the macro, channel 0 waits until the reti for channel 1.
